// File: rtl/lcd_pkg.sv
// Shared LCD1602 command bytes, arbiter state encoding and small elaboration helpers.
// The CLR_WAIT state only exists when LCD_CLEAR_HOLDOFF_EN is defined.
package lcd_pkg;

  localparam logic [7:0] CLEAR_DISPLAY             = 8'h01;
  localparam logic [7:0] SHIFT_CURSOR_RIGHT        = 8'h06;
  localparam logic [7:0] DISPON_CURSOROFF          = 8'h0C;
  localparam logic [7:0] LINES2_MATRIX5x8_MODE8bit = 8'h38;
  localparam logic [7:0] START_2LINE               = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3
`ifdef LCD_CLEAR_HOLDOFF_EN
    ,
    ST_CLR_WAIT = 3'd4
`endif
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake and LCD1602 bus signals of lcd_bus_arbiter.
// master = the requesters/environment, slave = the arbiter.
interface lcd_bus_arbiter_if #(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   rs_in;
  logic [8*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]   lock;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   ack;
  logic                 rs;
  logic                 rw;
  logic                 enable;
  logic [7:0]           data;
  logic                 busy;

  modport master (
    output req, rs_in, data_in, lock,
    input  gnt, ack, rs, rw, enable, data, busy
  );

  modport slave (
    input  req, rs_in, data_in, lock,
    output gnt, ack, rs, rw, enable, data, busy
  );

endinterface

// File: rtl/lcd_rr_picker.sv
// Round-robin request picker: searches upward from i_ptr, wrapping at NUM_REQ-1.
// Purely combinational; o_winner is one-hot, o_valid flags any request.
module lcd_rr_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_winner,
  output logic                       o_valid
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] w_idx;

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = i_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_valid && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        o_valid         = 1'b1;
      end
      w_idx = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + PW'(1);
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one LCD1602 bus between NUM_REQ requesters, with burst lock.
// Optional macro LCD_CLEAR_HOLDOFF_EN adds an idle hold-off after a clear-display command.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ           = 3,
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 4,
  parameter int HOLD_CYCLES       = 2,
  parameter int CLEAR_WAIT_CYCLES = 80000
) (
  input logic               clk,
  input logic               reset,
  lcd_bus_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NUM_REQ);
`ifdef LCD_CLEAR_HOLDOFF_EN
  localparam int MAX_CYC = max_int(max_int(SETUP_CYCLES, PULSE_CYCLES),
                                   max_int(HOLD_CYCLES, CLEAR_WAIT_CYCLES));
`else
  localparam int MAX_CYC = max_int(max_int(SETUP_CYCLES, PULSE_CYCLES), HOLD_CYCLES);
`endif
  localparam int CW = $clog2(MAX_CYC + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SETUP_CYCLES < 1 || PULSE_CYCLES < 1 ||
      HOLD_CYCLES < 1 || CLEAR_WAIT_CYCLES < 1) begin : g_bad_param
    $error("lcd_bus_arbiter: parameter out of range");
  end

  arb_state_e         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic               r_rs, w_rs_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic [PW-1:0]      r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_winner, w_sel;
  logic               w_valid, w_lock_hit;

  lcd_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_gnt_nxt   = r_gnt;
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    w_ptr_nxt   = r_ptr;
    // r_gnt still names the previous winner in IDLE, so only that requester's lock counts.
    w_lock_hit  = |(r_gnt & bus.lock & bus.req);
    w_sel       = w_lock_hit ? r_gnt : w_winner;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_lock_hit || w_valid) begin
          w_state_nxt = ST_SETUP;
          w_gnt_nxt   = w_sel;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel[i]) begin
              w_rs_nxt   = bus.rs_in[i];
              w_data_nxt = bus.data_in[8*i +: 8];
              if (!w_lock_hit) w_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
          end
        end else begin
          w_gnt_nxt = '0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = '0;
        end
      end
      ST_PULSE: begin
        if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
          w_cnt_nxt = '0;
`ifdef LCD_CLEAR_HOLDOFF_EN
          w_state_nxt = (!r_rs && r_data == CLEAR_DISPLAY) ? ST_CLR_WAIT : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef LCD_CLEAR_HOLDOFF_EN
      ST_CLR_WAIT: begin
        if (r_cnt == CW'(CLEAR_WAIT_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_rs    <= 1'b0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_rs    <= w_rs_nxt;
      r_data  <= w_data_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.ack    = (r_state == ST_HOLD && r_cnt == CW'(HOLD_CYCLES - 1)) ? r_gnt : '0;
  assign bus.rs     = r_rs;
  assign bus.rw     = 1'b0;
  assign bus.data   = r_data;
  assign bus.enable = (r_state == ST_PULSE);
  assign bus.busy   = (r_state != ST_IDLE);

endmodule
